mac_accumulator: RTL
====================

MAC_ACCUMULATOR -- requirements
Module: mac_accumulator

Interface
REQ-001 Parameter ACC_W, default 24, accumulator and result width in bits (legal range 16..40).
REQ-002 Parameter LEN_W, default 8, width of the product-count field.
REQ-003 Port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 Port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 Port start  input  1  single-cycle request to begin a new accumulation.
REQ-006 Port len  input  LEN_W  number of products in the accumulation; sampled when start is accepted.
REQ-007 Port prod  input  16  signed two's-complement product from the 8x8 signed multiplier output p.
REQ-008 Port in_valid  input  1  prod is valid this cycle.
REQ-009 Port in_ready  output  1  block accepts prod this cycle.
REQ-010 Port out_valid  output  1  acc_out holds a final result.
REQ-011 Port out_ready  input  1  consumer accepts the result.
REQ-012 Port acc_out  output  ACC_W  signed accumulated sum.
REQ-013 Port busy  output  1  high in any state other than IDLE.
REQ-014 Port ovf  output  1  sticky signed-overflow flag for the current accumulation.

Function
REQ-015 FSM SHALL have the states IDLE, ACC and DONE.
REQ-016 In IDLE, start with len>0 SHALL clear the accumulator, clear ovf, load the counter with len and move to ACC.
REQ-017 In IDLE, start with len==0 SHALL clear the accumulator and ovf and move directly to DONE, with acc_out=0.
REQ-018 start SHALL be ignored outside IDLE, including in the cycle a DONE handshake completes.
REQ-019 in_ready SHALL be 1 only in ACC; a beat is a cycle with in_valid and in_ready both high.
REQ-020 Each beat SHALL add prod, sign-extended to ACC_W, to the accumulator and decrement the counter.
REQ-021 Cycles with in_valid low SHALL leave the accumulator and counter unchanged.
REQ-022 On the beat that brings the counter to zero, the FSM SHALL move to DONE, and out_valid SHALL be 1 in the next cycle.
REQ-023 In DONE, out_valid=1 and acc_out SHALL remain stable until out_ready=1; the FSM SHALL then return to IDLE in the next cycle.
REQ-024 acc_out SHALL always show the registered accumulator; it is meaningful only while out_valid=1.
REQ-025 Signed overflow on any beat SHALL set ovf, which stays 1 until the next accepted start.
REQ-026 In the default build, the sum SHALL wrap modulo 2^ACC_W.

Reset
REQ-027 While rst_n=0, the block SHALL immediately enter IDLE and drive in_ready=0, out_valid=0, busy=0, ovf=0 and acc_out=0, with the counter at 0.
REQ-028 Reset asserted mid-ACC or mid-DONE SHALL abandon the accumulation; no result is produced after reset is released.

Configuration
REQ-029 Macro MAC_ACCUMULATOR_SATURATE_EN: when defined, an overflowing sum SHALL clamp to +(2^(ACC_W-1))-1 or -(2^(ACC_W-1)); ovf still sets.
REQ-030 When MAC_ACCUMULATOR_SATURATE_EN is undefined, the wrap behaviour of REQ-026 applies, with no clamp logic present.

Structure
REQ-031 Shared package mac_pkg SHALL hold PROD_W=16 and the state enum type (IDLE, ACC, DONE).
REQ-032 Sub-module mac_acc_add SHALL contain the sign-extend, add, overflow-detect and optional clamp logic, and be purely combinational.
REQ-033 The FSM, counter and registers SHALL reside in mac_accumulator.

Verification
REQ-034 ACC_W=24, start len=3, beats 100, -50, 7 -> out_valid one cycle after the third beat, acc_out=57, ovf=0.
REQ-035 start with len=0 -> out_valid=1 in the next cycle, acc_out=0, no beats accepted (in_ready stays 0).
REQ-036 ACC_W=16, len=2, beats 16384 and 16384 -> default build gives acc_out=-32768 and ovf=1; SATURATE_EN build gives acc_out=32767 and ovf=1.
REQ-037 len=4 with in_valid toggled 1,0,0,1,1,0,1 and out_ready held 0 for 5 cycles -> exactly 4 beats summed, out_valid and acc_out stable for 5 cycles, IDLE one cycle after out_ready=1.
REQ-038 rst_n pulsed low after the second of four beats -> all outputs 0 immediately; after release, in_ready=0 and out_valid=0 until a new start.
REQ-039 start asserted during ACC and again in the cycle the DONE handshake completes -> both ignored, and the counter and accumulator are unaffected.

Source files
------------

// File: rtl/mac_pkg.sv
// Shared definitions for the MAC accumulator slice.
//   PROD_W  : width of the signed product coming from the 8x8 multiplier
//   state_e : accumulator control states (IDLE, ACC, DONE)
package mac_pkg;

  localparam int PROD_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage : mac_pkg

// File: rtl/mac_acc_add.sv
// Combinational accumulate step: sign-extends a product to the accumulator
// width, adds it to the current sum and flags signed overflow.
// Optional build macro: MAC_ACCUMULATOR_SATURATE_EN -- when defined, an
// overflowing sum clamps to the most positive / most negative value instead
// of wrapping. The overflow flag is reported in both builds.
//
// Ports:
//   acc_i  in   ACC_W   current accumulator value (signed)
//   prod_i in   PROD_W  product to add (signed)
//   sum_o  out  ACC_W   next accumulator value (wrapped or clamped)
//   ovf_o  out  1       signed overflow occurred on this add
module mac_acc_add
  import mac_pkg::*;
#(
  parameter int ACC_W = 24
) (
  input  logic signed [ACC_W-1:0]  acc_i,
  input  logic signed [PROD_W-1:0] prod_i,
  output logic signed [ACC_W-1:0]  sum_o,
  output logic                     ovf_o
);

  logic signed [ACC_W-1:0] prod_ext;
  logic signed [ACC_W-1:0] raw_sum;

`ifdef MAC_ACCUMULATOR_SATURATE_EN
  // Overflow can only happen when both operands share a sign, so the
  // accumulator sign alone tells which rail to clamp to.
  function automatic logic signed [ACC_W-1:0] saturate(
    input logic signed [ACC_W-1:0] raw,
    input logic                    ovf,
    input logic                    neg
  );
    if (!ovf) begin
      return raw;
    end else if (neg) begin
      return {1'b1, {(ACC_W-1){1'b0}}};
    end else begin
      return {1'b0, {(ACC_W-1){1'b1}}};
    end
  endfunction
`endif

  // Signed size cast performs the sign extension.
  assign prod_ext = ACC_W'(prod_i);
  assign raw_sum  = acc_i + prod_ext;

  // Same-sign operands producing an opposite-sign result.
  assign ovf_o = (acc_i[ACC_W-1] == prod_ext[ACC_W-1]) &&
                 (raw_sum[ACC_W-1] != acc_i[ACC_W-1]);

`ifdef MAC_ACCUMULATOR_SATURATE_EN
  assign sum_o = saturate(raw_sum, ovf_o, acc_i[ACC_W-1]);
`else
  assign sum_o = raw_sum;
`endif

endmodule : mac_acc_add

// File: rtl/mac_accumulator.sv
// Multiply-accumulate back end: sums a requested number of signed products
// from the multiplier and presents the result with a valid/ready handshake.
// Optional build macro: MAC_ACCUMULATOR_SATURATE_EN (clamp instead of wrap,
// implemented inside mac_acc_add).
//
// Ports:
//   clk        in   1       clock, rising edge
//   rst_n      in   1       asynchronous active-low reset
//   start      in   1       begin a new accumulation (honoured only in IDLE)
//   len        in   LEN_W   number of products, sampled with start
//   prod       in   PROD_W  signed product
//   in_valid   in   1       prod valid
//   in_ready   out  1       product accepted this cycle (ACC only)
//   out_valid  out  1       acc_out holds the final result (DONE)
//   out_ready  in   1       consumer takes the result
//   acc_out    out  ACC_W   registered accumulator
//   busy       out  1       not IDLE
//   ovf        out  1       sticky signed overflow for this accumulation
module mac_accumulator
  import mac_pkg::*;
#(
  parameter int ACC_W = 24,
  parameter int LEN_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [LEN_W-1:0]         len,
  input  logic signed [PROD_W-1:0] prod,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [ACC_W-1:0]  acc_out,
  output logic                     busy,
  output logic                     ovf
);

  state_e                  state_q, state_d;
  logic [LEN_W-1:0]        cnt_q, cnt_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic                    ovf_q, ovf_d;
  logic                    in_ready_q, out_valid_q, busy_q;

  logic signed [ACC_W-1:0] sum;
  logic                    add_ovf;

  mac_acc_add #(
    .ACC_W (ACC_W)
  ) u_add (
    .acc_i  (acc_q),
    .prod_i (prod),
    .sum_o  (sum),
    .ovf_o  (add_ovf)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          acc_d = '0;
          ovf_d = 1'b0;
          if (len != '0) begin
            cnt_d   = len;
            state_d = ACC;
          end else begin
            // Empty accumulation: result is zero, go straight to DONE.
            cnt_d   = '0;
            state_d = DONE;
          end
        end
      end
      ACC: begin
        // in_ready is high throughout ACC, so in_valid alone marks a beat.
        if (in_valid) begin
          acc_d = sum;
          ovf_d = ovf_q | add_ovf;
          cnt_d = cnt_q - LEN_W'(1);
          if (cnt_q == LEN_W'(1)) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        // start is deliberately not looked at here, even on the handshake.
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they line up with
  // state_q without a decode after the flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      ovf_q       <= ovf_d;
      in_ready_q  <= (state_d == ACC);
      out_valid_q <= (state_d == DONE);
      busy_q      <= (state_d != IDLE);
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign acc_out   = acc_q;
  assign ovf       = ovf_q;

endmodule : mac_accumulator
